reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  Debug reader for the CPU register file: on request, walks the file through one
//  combinational read port and streams each 32-bit value with its index over a
//  valid/ready link to the MMIO display/UART path. Full dump (x0..x31) or one register.
//  Sits beside the decode-stage read ports; never writes the register file.
// PARAMETERS
//  NUM_REGS  32  registers walked in full-dump mode; last index = NUM_REGS-1
//  ADDR_W    5   register address width
//  DATA_W    32  register data width
// PORTS
//  clk       in   1       clock
//  reset     in   1       reset, synchronous, active-high
//  start     in   1       1-cycle request; sampled only in IDLE
//  single    in   1       with start: 1 = dump sel_addr only, 0 = full dump
//  sel_addr  in   ADDR_W  register for single mode, sampled with start
//  rd_addr   out  ADDR_W  address to register-file read port
//  rd_data   in   DATA_W  combinational data from that read port
//  out_valid out  1       out_data/out_idx/out_last valid
//  out_ready in   1       consumer accepts beat when out_valid & out_ready
//  out_data  out  DATA_W  captured register value
//  out_idx   out  ADDR_W  index of out_data
//  out_last  out  1       final beat of this dump
//  busy      out  1       high in any state except IDLE
//  done      out  1       1-cycle pulse after final beat accepted
// BEHAVIOUR
//  Reset: state=IDLE; rd_addr=0, out_valid=0, out_data=0, out_idx=0, out_last=0,
//   busy=0, done=0. Reset in any state aborts dump on that edge; no partial done.
//  FSM IDLE -> READ -> SEND -> (READ | DONE) -> IDLE.
//  IDLE: start=1 latches mode; idx <= single ? sel_addr : 0; -> READ.
//  READ (1 cycle): rd_addr=idx; at edge out_data<=rd_data, out_idx<=idx,
//   out_last<=(single | idx==NUM_REGS-1), out_valid<=1; -> SEND.
//  SEND: out_* held stable while out_valid & !out_ready. On handshake: out_valid<=0;
//   if out_last -> DONE else idx<=idx+1, -> READ.
//  DONE (1 cycle): done=1; -> IDLE. busy=1 in READ/SEND/DONE.
//  Latency: start at edge N -> first out_valid from edge N+2; with out_ready held 1
//   each register takes 2 cycles; full dump done pulse at cycle N+2*NUM_REGS+1.
//  rd_addr holds last driven value outside READ (no spurious toggling).
//  idx never exceeds NUM_REGS-1; no wrap; sel_addr>=NUM_REGS in single mode still
//   dumps that one address (read port defines value).
//  start while busy: ignored, not queued. start on same edge as reset: reset wins.
//  Coherence: each value sampled at its own READ cycle; register-file writes during
//   a dump appear for indices not yet read. x0 reads as 0 via the read port.
//  out_ready high while out_valid=0 has no effect.
// TESTING
//  T1 reset: assert reset 2 cycles mid-idle -> all outputs 0, busy=0, done=0.
//  T2 full dump, out_ready=1, x2=0x7FFFF000, x5=0xDEADBEEF, others 0 -> 32 beats,
//   idx 0..31 in order, beat2=0x7FFFF000, beat5=0xDEADBEEF, out_last only on idx 31,
//   done 1 cycle at start+65.
//  T3 backpressure: out_ready=0 for 5 cycles on idx 3 -> out_valid,out_data,out_idx
//   stable all 5 cycles; beat accepted once; idx 4 follows; no beat lost/duplicated.
//  T4 single mode sel_addr=5 -> exactly one beat {idx=5, data=0xDEADBEEF, last=1};
//   done pulse; busy falls next cycle.
//  T5 start pulsed during beat 10 of full dump -> ignored; dump completes 32 beats.
//  T6 reset asserted during SEND of idx 7 -> next cycle IDLE, out_valid=0, no done;
//   new start afterwards dumps from idx 0.

Source files
------------

// File: rtl/reg_dump_reader.sv
// Debug reader that walks the register file through one combinational read port and
// streams {index, value} beats over a valid/ready link. Full dump or a single register.
module reg_dump_reader #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              single,
    input  logic [ADDR_W-1:0] sel_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              single_mode;

    // rd_addr is loaded on entry to READ so it is already valid during that cycle
    // and otherwise holds its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            idx         <= '0;
            single_mode <= 1'b0;
            rd_addr     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        single_mode <= single;
                        idx         <= single ? sel_addr : '0;
                        rd_addr     <= single ? sel_addr : '0;
                        busy        <= 1'b1;
                        state       <= StRead;
                    end
                end
                StRead: begin
                    out_data  <= rd_data;
                    out_idx   <= idx;
                    out_last  <= single_mode || (idx == LAST_IDX);
                    out_valid <= 1'b1;
                    state     <= StSend;
                end
                StSend: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else begin
                            idx     <= idx + 1'b1;
                            rd_addr <= idx + 1'b1;
                            state   <= StRead;
                        end
                    end
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: register file model on the read port, beat
// collector with optional backpressure and ignored mid-dump start, reset abort.
module tb_reg_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        single;
    logic [4:0]  sel_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int checks = 0;
    int errors = 0;

    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    reg_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .single    (single),
        .sel_addr  (sel_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one dump from IDLE. t counts edges after the cycle start was driven in.
    task automatic dump(input string tag, input bit sgl, input logic [4:0] sel,
                        input int stall_idx, input int stall_len, input int restart_idx,
                        input int exp_beats, input int exp_done_t);
        int t;
        int beats;
        int dones;
        int done_t;
        int first_valid;
        int stall_cnt;
        bit restarted;
        bit finished;
        logic [31:0] held_d;
        logic [4:0]  held_i;
        logic [4:0]  exp_i;
        beats = 0; dones = 0; done_t = -1; first_valid = -1;
        stall_cnt = 0; restarted = 0; finished = 0;
        held_d = '0; held_i = '0;
        single = sgl; sel_addr = sel; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        t = 1;
        while (t < 300) begin
            start = 1'b0;
            if (done_t >= 0 && t == done_t + 1) begin
                chk({tag, " busy after done"}, {31'b0, busy}, 32'd0);
                finished = 1;
                break;
            end
            if (done) begin
                dones++;
                done_t = t;
                chk({tag, " busy during done"}, {31'b0, busy}, 32'd1);
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = t;
                if (int'(out_idx) == stall_idx && stall_cnt < stall_len) begin
                    if (stall_cnt == 0) begin
                        held_d = out_data;
                        held_i = out_idx;
                    end else begin
                        chk({tag, " stall data"}, out_data, held_d);
                        chk({tag, " stall idx"}, {27'b0, out_idx}, {27'b0, held_i});
                    end
                    out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_ready = 1'b1;
                    exp_i = sgl ? sel : 5'(beats);
                    chk({tag, " idx"}, {27'b0, out_idx}, {27'b0, exp_i});
                    chk({tag, " data"}, out_data, regs[exp_i]);
                    chk({tag, " last"}, {31'b0, out_last},
                        {31'b0, (sgl || exp_i == 5'd31)});
                    beats++;
                    if (int'(out_idx) == restart_idx && !restarted) begin
                        start = 1'b1;
                        restarted = 1;
                    end
                end
            end else begin
                out_ready = 1'b1;
            end
            tick();
            t++;
        end
        chk({tag, " finished in bound"}, {31'b0, finished}, 32'd1);
        chk({tag, " beat count"}, beats, exp_beats);
        chk({tag, " done pulses"}, dones, 32'd1);
        chk({tag, " done cycle"}, done_t, exp_done_t);
        chk({tag, " first valid cycle"}, first_valid, 32'd2);
        if (stall_len > 0) chk({tag, " stall cycles"}, stall_cnt, stall_len);
    endtask

    initial begin
        int n;
        int bad;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[2] = 32'h7FFF_F000;
        regs[5] = 32'hDEAD_BEEF;
        reset = 1'b1; start = 1'b0; single = 1'b0; sel_addr = '0; out_ready = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // T1: two-cycle reset while idle; start on the reset edge must lose.
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b0;
        chk("T1 rd_addr", {27'b0, rd_addr}, 32'd0);
        chk("T1 out_valid", {31'b0, out_valid}, 32'd0);
        chk("T1 out_data", out_data, 32'd0);
        chk("T1 out_idx", {27'b0, out_idx}, 32'd0);
        chk("T1 out_last", {31'b0, out_last}, 32'd0);
        chk("T1 busy", {31'b0, busy}, 32'd0);
        chk("T1 done", {31'b0, done}, 32'd0);
        tick();
        chk("T1 still idle", {31'b0, busy}, 32'd0);

        // T2: full dump, ready held high.
        dump("T2", 1'b0, 5'd0, -1, 0, -1, 32, 65);
        tick();
        // T3: 5-cycle backpressure on idx 3.
        dump("T3", 1'b0, 5'd0, 3, 5, -1, 32, 70);
        tick();
        // T4: single register 5.
        dump("T4", 1'b1, 5'd5, -1, 0, -1, 1, 3);
        tick();
        // T5: start pulsed while beat 10 is on the link.
        dump("T5", 1'b0, 5'd0, -1, 0, 10, 32, 65);
        tick();

        // T6: reset while idx 7 waits in SEND.
        single = 1'b0; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 40 && !(out_valid && out_idx == 5'd7)) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("T6 reached idx 7", {31'b0, (out_valid && out_idx == 5'd7)}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("T6 out_valid", {31'b0, out_valid}, 32'd0);
        chk("T6 busy", {31'b0, busy}, 32'd0);
        chk("T6 done", {31'b0, done}, 32'd0);
        chk("T6 rd_addr", {27'b0, rd_addr}, 32'd0);
        bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || busy || out_valid) bad++;
        end
        chk("T6 quiet after abort", bad, 32'd0);
        dump("T6 restart", 1'b0, 5'd0, -1, 0, -1, 32, 65);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
